mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller inside cpu. Arbitrates word-level requests from the instruction fetch unit and the load/store buffer.
- Drives the 8-bit system memory bus (mem_a/mem_wr/mem_dout/mem_din) that the top level muxes to ram and hci.
- Serialises 1/2/4-byte accesses little-endian. Honours rdy_in pauses and io_buffer_full on I/O writes.

Parameters:
- RAM_ADDR_WIDTH, 17, I/O region decode: access is I/O when addr[RAM_ADDR_WIDTH:RAM_ADDR_WIDTH-1]==2'b11 (0x30000 and up).

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  bus granted; low = hci owns the bus, controller frozen.
- io_buffer_full  input  1  hci output FIFO full.
- mem_din  input  8  read byte, valid one cycle after its address.
- mem_dout  output  8  write byte.
- mem_a  output  32  byte address.
- mem_wr  output  1  1 = write.
- if_req  input  1  fetch request (4-byte read), held until if_done.
- if_addr  input  32  fetch address.
- if_clear  input  1  abort pending/active fetch.
- if_done  output  1  one-cycle pulse, if_data valid.
- if_data  output  32  fetched word.
- ls_req  input  1  load/store request, held until ls_done.
- ls_wr  input  1  1 = store.
- ls_size  input  2  0 = byte, 1 = half, 2 = word.
- ls_addr  input  32  address.
- ls_wdata  input  32  store data (low bytes used).
- ls_done  output  1  one-cycle pulse.
- ls_rdata  output  32  load data, zero-extended; sign extension is done in the LSB.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (async, rst_n_in=0): state IDLE; mem_a=0, mem_wr=0, mem_dout=0; if_done=0, ls_done=0, if_data=0, ls_rdata=0, busy=0; counters 0. Reset mid-transaction aborts it immediately; mem_wr drops in the same cycle.
- States: IDLE, READ, WRITE.
  - IDLE: ls_req has priority over if_req.
  - Accept cycle A: latch addr, size (fetch = 4), wdata and owner. Go to READ or WRITE. Bus idle in A (mem_wr=0, mem_a=0).
  - n = 1/2/4 bytes.
- READ:
  - Issue counter iss drives mem_a = base+iss for cycles A+1..A+n.
  - Receive counter rcv captures mem_din into byte lane rcv on each edge after its issue cycle.
  - Bytes land at edges ending A+2..A+n+1.
  - Done pulse plus data in cycle A+n+2, then back to IDLE. Word read: done 6 cycles after accept.
  - Back-to-back: a new request is accepted no earlier than the cycle after done.
- WRITE:
  - Cycles A+1..A+n: mem_wr=1, mem_a = base+k, mem_dout = wdata[8k+7:8k].
  - Done pulse in A+n+1.
  - If the access is I/O and io_buffer_full=1: mem_wr=0 and k holds until full clears.
- rdy_in=0:
  - No counter or state advance; mem_wr forced 0; done outputs held 0; pending done is delayed, not lost.
  - Any byte in flight is discarded. On rdy_in return, iss is reset to rcv and that byte is reissued.
- if_clear:
  - In IDLE, suppresses if_req that cycle.
  - In READ for a fetch, returns to IDLE next cycle with no if_done; late mem_din bytes are ignored.
  - Never affects ls transactions.
  - if_clear and ls_req in the same IDLE cycle: ls accepted.
- I/O accesses must be size 0; I/O reads are never replayed twice unless rdy_in drops.
- Address arithmetic: base+k in 32 bits, wraps mod 2^32. Misaligned accesses are allowed and serialised unchanged.
- ls_rdata and if_data hold their value until the next done of the same owner.

Decomposition:
- Package cpu_pkg: state encoding (MC_IDLE/MC_READ/MC_WRITE), size constants (SZ_B/SZ_H/SZ_W), and the I/O decode function.
- No sub-module is needed. The byte assembler is inline logic: a 4-lane register with lane-write enable.

Test Plan:
- Fetch 0x1000, ram bytes 13 05 00 00; accept at cycle 10 -> mem_a 0x1000..0x1003 in cycles 11..14; if_done in cycle 16 with if_data=0x00000513.
- Word store 0xDEADBEEF to 0x2000 -> mem_wr=1 in 4 consecutive cycles with bytes EF BE AD DE at 0x2000..0x2003; ls_done the next cycle.
- Byte store 0x41 to 0x30000; io_buffer_full high for 3 cycles after accept -> mem_wr=0 for those 3 cycles, then one write cycle with mem_dout=0x41, then ls_done.
- if_req and ls_req (load half 0x3004, ram bytes 34 12) raised together -> ls served first, ls_rdata=0x00001234; the fetch starts the cycle after ls_done.
- rdy_in low for 2 cycles after the byte 1 issue of a word load -> byte 1 is reissued after resume; the final word is correct and done is delayed by exactly the stall plus replay.
- if_clear during fetch byte 2 -> no if_done; busy=0 the next cycle; a following ls store runs normally. Separately, rst_n_in low mid-write -> mem_wr=0 immediately and all outputs take their reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory controller.
//   mc_state_e  : controller FSM encoding (MC_IDLE / MC_READ / MC_WRITE)
//   SZ_*        : load/store size codes as seen on ls_size
//   size_bytes  : size code -> byte count (1/2/4)
//   is_io_addr  : I/O region decode, addr[aw:aw-1] == 2'b11
package cpu_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_READ  = 2'd1,
    MC_WRITE = 2'd2
  } mc_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  // Undefined size code 3 is treated as a word access.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io_addr(input logic [31:0] addr, input int aw);
    logic [31:0] sh;
    sh = addr >> (aw - 1);
    return (sh[1:0] == 2'b11);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller. Arbitrates word-level requests from the
// instruction fetch unit (if_*) and the load/store buffer (ls_*) onto the
// 8-bit system memory bus, serialising 1/2/4-byte accesses little-endian.
//
// Ports:
//   clk_in, rst_n_in      clock, async active-low reset
//   rdy_in                bus granted; low freezes the controller
//   io_buffer_full        hci output FIFO full (stalls I/O writes)
//   mem_din/mem_dout      read byte (one cycle after address) / write byte
//   mem_a, mem_wr         byte address, write strobe
//   if_req/if_addr/if_clear -> if_done/if_data       4-byte fetch port
//   ls_req/ls_wr/ls_size/ls_addr/ls_wdata -> ls_done/ls_rdata  load/store port
//   busy                  controller not idle
//
// state    | meaning
// ---------+--------------------------------------------------------------
// MC_IDLE  | bus idle; accepts ls_req first, then if_req (unless if_clear)
// MC_READ  | issuing addresses (iss) and collecting bytes (rcv); done at rcv==n
// MC_WRITE | one byte per cycle at base+iss; done once iss==n
module mem_ctrl
  import cpu_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_clear,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        busy
);

  mc_state_e   state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  n_q, n_d;
  logic        own_ls_q, own_ls_d;
  logic        io_q, io_d;
  logic [2:0]  iss_q, iss_d;
  logic [2:0]  rcv_q, rcv_d;
  logic        pend_q, pend_d;    // a read byte was issued last cycle
  logic [31:0] buf_q, buf_d;      // byte assembler, cleared at accept
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] ls_rdata_q, ls_rdata_d;
  logic        rd_done;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= MC_IDLE;
      base_q     <= '0;
      wdata_q    <= '0;
      n_q        <= '0;
      own_ls_q   <= 1'b0;
      io_q       <= 1'b0;
      iss_q      <= '0;
      rcv_q      <= '0;
      pend_q     <= 1'b0;
      buf_q      <= '0;
      if_data_q  <= '0;
      ls_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      n_q        <= n_d;
      own_ls_q   <= own_ls_d;
      io_q       <= io_d;
      iss_q      <= iss_d;
      rcv_q      <= rcv_d;
      pend_q     <= pend_d;
      buf_q      <= buf_d;
      if_data_q  <= if_data_d;
      ls_rdata_q <= ls_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    n_d        = n_q;
    own_ls_d   = own_ls_q;
    io_d       = io_q;
    iss_d      = iss_q;
    rcv_d      = rcv_q;
    pend_d     = pend_q;
    buf_d      = buf_q;
    if_data_d  = if_data_q;
    ls_rdata_d = ls_rdata_q;
    mem_a      = '0;
    mem_wr     = 1'b0;
    mem_dout   = '0;
    if_done    = 1'b0;
    ls_done    = 1'b0;
    rd_done    = 1'b0;

    unique case (state_q)
      MC_IDLE: begin
        if (rdy_in) begin
          if (ls_req) begin
            base_d   = ls_addr;
            wdata_d  = ls_wdata;
            n_d      = size_bytes(ls_size);
            own_ls_d = 1'b1;
            io_d     = is_io_addr(ls_addr, RAM_ADDR_WIDTH);
            iss_d    = '0;
            rcv_d    = '0;
            pend_d   = 1'b0;
            buf_d    = '0;
            state_d  = ls_wr ? MC_WRITE : MC_READ;
          end else if (if_req && !if_clear) begin
            base_d   = if_addr;
            n_d      = 3'd4;
            own_ls_d = 1'b0;
            io_d     = is_io_addr(if_addr, RAM_ADDR_WIDTH);
            iss_d    = '0;
            rcv_d    = '0;
            pend_d   = 1'b0;
            buf_d    = '0;
            state_d  = MC_READ;
          end
        end
      end

      MC_READ: begin
        if (!own_ls_q && if_clear) begin
          // Aborted fetch: any byte still in flight is simply never captured.
          pend_d  = 1'b0;
          state_d = MC_IDLE;
        end else if (!rdy_in) begin
          // Bus lost: drop the in-flight byte and replay from the first
          // byte not yet received.
          iss_d  = rcv_q;
          pend_d = 1'b0;
        end else begin
          pend_d = 1'b0;
          if (pend_q) begin
            case (rcv_q[1:0])
              2'd0:    buf_d[7:0]   = mem_din;
              2'd1:    buf_d[15:8]  = mem_din;
              2'd2:    buf_d[23:16] = mem_din;
              default: buf_d[31:24] = mem_din;
            endcase
            rcv_d = rcv_q + 3'd1;
          end
          if (iss_q < n_q) begin
            mem_a  = base_q + {29'b0, iss_q};
            iss_d  = iss_q + 3'd1;
            pend_d = 1'b1;
          end
          if (rcv_q == n_q) begin
            rd_done = 1'b1;
            state_d = MC_IDLE;
            if (own_ls_q) begin
              ls_done    = 1'b1;
              ls_rdata_d = buf_q;
            end else begin
              if_done   = 1'b1;
              if_data_d = buf_q;
            end
          end
        end
      end

      MC_WRITE: begin
        if (rdy_in) begin
          if (iss_q < n_q) begin
            if (!(io_q && io_buffer_full)) begin
              mem_wr   = 1'b1;
              mem_a    = base_q + {29'b0, iss_q};
              mem_dout = wdata_q[{iss_q[1:0], 3'b000} +: 8];
              iss_d    = iss_q + 3'd1;
            end
          end else begin
            ls_done = 1'b1;
            state_d = MC_IDLE;
          end
        end
      end

      default: state_d = MC_IDLE;
    endcase
  end

  // Read data is shown straight from the assembler in the done cycle and
  // from the per-owner hold register afterwards.
  assign if_data  = if_done ? buf_q : if_data_q;
  assign ls_rdata = (rd_done && own_ls_q) ? buf_q : ls_rdata_q;
  assign busy     = (state_q != MC_IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk_in, rst_n_in, rdy_in, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        if_req, if_clear, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
  typedef struct { bit ls; logic [31:0] data; bit chk; int cyc; } done_t;
  wr_t   exp_wr_q[$];
  done_t exp_done_q[$];

  logic [7:0] ram [logic [31:0]];

  mem_ctrl #(.RAM_ADDR_WIDTH(17)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .io_buffer_full(io_buffer_full), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr),
    .if_req(if_req), .if_addr(if_addr), .if_clear(if_clear),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .busy(busy)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  always @(posedge clk_in) cyc <= cyc + 1;

  // RAM: byte for the address of the previous cycle.
  always @(posedge clk_in) mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

  // Scoreboard monitor for bus writes and done pulses.
  always @(negedge clk_in) begin
    wr_t ew;
    done_t ed;
    logic [31:0] got;
    if (rst_n_in) begin
      if (mem_wr) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr %h data %h at cycle %0d, none expected", mem_a, mem_dout, cyc);
        end else begin
          ew = exp_wr_q.pop_front();
          if (mem_a !== ew.addr || mem_dout !== ew.data) begin
            errors++;
            $display("FAIL write_byte: got addr %h data %h, expected addr %h data %h", mem_a, mem_dout, ew.addr, ew.data);
          end
        end
      end
      if (if_done || ls_done) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected: if_done %b ls_done %b at cycle %0d", if_done, ls_done, cyc);
        end else begin
          ed = exp_done_q.pop_front();
          got = ed.ls ? ls_rdata : if_data;
          if (ls_done !== ed.ls || if_done !== !ed.ls || cyc !== ed.cyc || (ed.chk && got !== ed.data)) begin
            errors++;
            $display("FAIL done: got ls %b if %b data %h cycle %0d, expected ls %b data %h cycle %0d",
                     ls_done, if_done, got, cyc, ed.ls, ed.data, ed.cyc);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    if_req = 0; if_addr = '0; if_clear = 0;
    ls_req = 0; ls_wr = 0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
    #2 rst_n_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #2;
    checks++;
    if (mem_a !== 32'h0 || mem_wr !== 1'b0 || mem_dout !== 8'h0) begin
      errors++; $display("FAIL reset_bus: got a %h wr %b dout %h, expected all 0", mem_a, mem_wr, mem_dout);
    end
    checks++;
    if (if_done !== 1'b0 || ls_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got if_done %b ls_done %b busy %b, expected 0", if_done, ls_done, busy);
    end
    checks++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got if_data %h ls_rdata %h, expected 0", if_data, ls_rdata);
    end
    next_cycle();
    rst_n_in = 1'b1;
    repeat (2) next_cycle();
  endtask

  task automatic test_fetch();
    int a;
    bit seen;
    next_cycle();
    a = cyc;
    if_req = 1; if_addr = 32'h1000;
    exp_done_q.push_back('{1'b0, 32'h00000513, 1'b1, a + 6});
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      next_cycle(); #1;
      if (k <= 4) begin
        checks++;
        if (mem_a !== 32'h1000 + k - 1 || mem_wr !== 1'b0) begin
          errors++; $display("FAIL fetch_addr: got a %h wr %b, expected a %h wr 0", mem_a, mem_wr, 32'h1000 + k - 1);
        end
      end
      if (if_done) seen = 1;
    end
    if_req = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL fetch_timeout: got no if_done, expected one"); end
  endtask

  task automatic test_store_word();
    int a;
    bit seen;
    next_cycle();
    a = cyc;
    ls_req = 1; ls_wr = 1; ls_size = 2'd2; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF;
    exp_wr_q.push_back('{32'h2000, 8'hEF});
    exp_wr_q.push_back('{32'h2001, 8'hBE});
    exp_wr_q.push_back('{32'h2002, 8'hAD});
    exp_wr_q.push_back('{32'h2003, 8'hDE});
    exp_done_q.push_back('{1'b1, 32'h0, 1'b0, a + 5});
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      next_cycle(); #1;
      if (k <= 5) begin
        checks++;
        if (mem_wr !== (k <= 4)) begin
          errors++; $display("FAIL store_wr: got mem_wr %b at offset %0d, expected %b", mem_wr, k, (k <= 4));
        end
      end
      if (ls_done) seen = 1;
    end
    ls_req = 0; ls_wr = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL store_timeout: got no ls_done, expected one"); end
  endtask

  task automatic test_io_store();
    int a;
    bit seen;
    next_cycle();
    a = cyc;
    ls_req = 1; ls_wr = 1; ls_size = 2'd0; ls_addr = 32'h30000; ls_wdata = 32'h00000041;
    exp_wr_q.push_back('{32'h30000, 8'h41});
    exp_done_q.push_back('{1'b1, 32'h0, 1'b0, a + 5});
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      next_cycle();
      io_buffer_full = (k <= 3);
      #1;
      if (k <= 4) begin
        checks++;
        if (mem_wr !== (k == 4)) begin
          errors++; $display("FAIL io_full_wr: got mem_wr %b at offset %0d, expected %b", mem_wr, k, (k == 4));
        end
      end
      if (ls_done) seen = 1;
    end
    io_buffer_full = 0; ls_req = 0; ls_wr = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL io_timeout: got no ls_done, expected one"); end
  endtask

  task automatic test_priority();
    int a;
    bit ls_seen, if_seen;
    next_cycle();
    a = cyc;
    ls_req = 1; ls_wr = 0; ls_size = 2'd1; ls_addr = 32'h3004;
    if_req = 1; if_addr = 32'h1000;
    exp_done_q.push_back('{1'b1, 32'h00001234, 1'b1, a + 4});
    exp_done_q.push_back('{1'b0, 32'h00000513, 1'b1, a + 11});
    ls_seen = 0; if_seen = 0;
    for (int k = 1; k <= 30 && !if_seen; k++) begin
      next_cycle(); #1;
      if (k == 6) begin
        checks++;
        if (mem_a !== 32'h1000 || busy !== 1'b1) begin
          errors++; $display("FAIL prio_fetch_start: got a %h busy %b, expected a 00001000 busy 1", mem_a, busy);
        end
      end
      if (ls_done) begin ls_req = 0; ls_seen = 1; end
      if (if_done) begin if_req = 0; if_seen = 1; end
    end
    checks++;
    if (!ls_seen || !if_seen) begin
      errors++; $display("FAIL prio_timeout: got ls_seen %b if_seen %b, expected both 1", ls_seen, if_seen);
    end
    next_cycle(); #1;
    checks++;
    if (ls_rdata !== 32'h00001234) begin
      errors++; $display("FAIL ls_rdata_hold: got %h, expected 00001234", ls_rdata);
    end
  endtask

  task automatic test_stall();
    int a;
    bit seen;
    next_cycle();
    a = cyc;
    ls_req = 1; ls_wr = 0; ls_size = 2'd2; ls_addr = 32'h4000;
    exp_done_q.push_back('{1'b1, 32'h44332211, 1'b1, a + 9});
    seen = 0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      next_cycle();
      rdy_in = !(k == 3 || k == 4);
      #1;
      if (k == 5) begin
        checks++;
        if (mem_a !== 32'h4001) begin
          errors++; $display("FAIL stall_replay: got a %h, expected 00004001", mem_a);
        end
      end
      if (ls_done) seen = 1;
    end
    rdy_in = 1; ls_req = 0;
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_timeout: got no ls_done, expected one"); end
  endtask

  task automatic test_clear();
    int a;
    bit if_seen, ls_seen;
    next_cycle();
    a = cyc;
    if_req = 1; if_addr = 32'h1000;
    if_seen = 0; ls_seen = 0;
    for (int k = 1; k <= 14; k++) begin
      next_cycle();
      case (k)
        3: begin if_clear = 1; if_req = 0; end
        4: begin if_clear = 1; if_req = 1; end
        5: begin
          if_clear = 1; if_req = 1;
          ls_req = 1; ls_wr = 1; ls_size = 2'd0; ls_addr = 32'h2010; ls_wdata = 32'h0000005A;
          exp_wr_q.push_back('{32'h2010, 8'h5A});
          exp_done_q.push_back('{1'b1, 32'h0, 1'b0, a + 7});
        end
        6: begin if_clear = 0; if_req = 0; end
        default: ;
      endcase
      #1;
      if (k == 4 || k == 5) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL clear_idle: got busy %b at offset %0d, expected 0", busy, k);
        end
      end
      if (k == 6) begin
        checks++;
        if (busy !== 1'b1 || mem_wr !== 1'b1) begin
          errors++; $display("FAIL clear_ls_accept: got busy %b wr %b, expected 1 1", busy, mem_wr);
        end
      end
      if (if_done) if_seen = 1;
      if (ls_done) begin ls_seen = 1; ls_req = 0; ls_wr = 0; end
    end
    checks++;
    if (if_seen || !ls_seen) begin
      errors++; $display("FAIL clear_done: got if_done seen %b ls_done seen %b, expected 0 1", if_seen, ls_seen);
    end
    checks++;
    if (if_data !== 32'h00000513) begin
      errors++; $display("FAIL clear_if_data_hold: got %h, expected 00000513", if_data);
    end
  endtask

  task automatic test_reset_mid_write();
    next_cycle();
    ls_req = 1; ls_wr = 1; ls_size = 2'd2; ls_addr = 32'h2100; ls_wdata = 32'hCAFEF00D;
    exp_wr_q.push_back('{32'h2100, 8'h0D});
    next_cycle();
    next_cycle(); #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_a !== 32'h2101) begin
      errors++; $display("FAIL rstmid_pre: got wr %b a %h, expected 1 00002101", mem_wr, mem_a);
    end
    rst_n_in = 0;
    #1;
    checks++;
    if (mem_wr !== 1'b0 || mem_a !== 32'h0 || mem_dout !== 8'h0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_bus: got wr %b a %h dout %h busy %b, expected all 0", mem_wr, mem_a, mem_dout, busy);
    end
    checks++;
    if (if_data !== 32'h0 || ls_rdata !== 32'h0 || if_done !== 1'b0 || ls_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_out: got if_data %h ls_rdata %h if_done %b ls_done %b, expected 0",
                         if_data, ls_rdata, if_done, ls_done);
    end
    ls_req = 0; ls_wr = 0;
    next_cycle();
    rst_n_in = 1;
    next_cycle(); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_after: got busy %b, expected 0", busy); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish within time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
    ram[32'h3004] = 8'h34; ram[32'h3005] = 8'h12;
    ram[32'h4000] = 8'h11; ram[32'h4001] = 8'h22; ram[32'h4002] = 8'h33; ram[32'h4003] = 8'h44;
    test_reset();
    test_fetch();
    test_store_word();
    test_io_store();
    test_priority();
    test_stall();
    test_clear();
    test_reset_mid_write();
    repeat (2) next_cycle();
    checks++;
    if (exp_wr_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d writes %0d dones outstanding, expected 0 0",
                         exp_wr_q.size(), exp_done_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
